protobuf_varint_encoder: RTL and testbench
==========================================

// Module: protobuf_varint_encoder
// PURPOSE
//  Second-generation protobuf varint engine for the serializer datapath. Accepts one typed
//  integer per handshake and optionally prefixes a field key (field_num<<3 | wire type 0).
//  Emits the LEB128 varint byte stream (7 bits per byte, LSB group first, MSB = continuation)
//  through an output FIFO with valid/ready backpressure.
//  Adds over the previous engine: native 64-bit input, int32 sign-extension, zigzag, key emission.
// PARAMETERS
//  FIFO_DEPTH  32  output FIFO entries (power of 2, >=16); each entry {last, byte[7:0]}
//  FIELD_W     5   width of in_field; key = {in_field,3'b000}, at most 2 bytes at default
//  TAG_EN      1   1: key emission is honoured when in_tag=1; 0: in_tag/in_field are ignored
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  in_valid     in   1        input word valid
//  in_ready     out  1        encoder can accept a word
//  in_data      in   64       value; upper 32 bits ignored for RAW32/INT32
//  in_kind      in   2        0 RAW32 (zero-ext), 1 RAW64, 2 INT32 (sign-ext to 64), 3 SINT64 (zigzag)
//  in_tag       in   1        prefix field key before value
//  in_field     in   FIELD_W  protobuf field number
//  m_valid      out  1        output byte valid
//  m_ready      in   1        downstream accepts byte
//  m_data       out  8        output byte
//  m_last       out  1        final byte of the current message (key+value)
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  msg_done     out  1        one-cycle pulse when last byte of a message is written into the FIFO
//  msg_len      out  4        byte count of that message (1..12), valid with msg_done
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, FIFO empty. Outputs: in_ready=0 during reset, 1 first cycle
//   after release. m_valid=0, m_data=0, m_last=0, fifo_level=0, msg_done=0, msg_len=0.
//   Reset mid-message discards all partial and buffered bytes.
//  Normalise on accept (in_valid&in_ready): v64 = RAW32: {32'b0,d[31:0]}; RAW64: d;
//   INT32: {{32{d[31]}},d[31:0]}; SINT64: (d<<1) ^ {64{d[63]}}.
//   Key k = {in_field,3'b000} latched the same cycle.
//  FSM: IDLE -> (accept & tag) KEY | (accept & !tag) BODY.
//   KEY: one key byte/cycle -> BODY after last key byte.
//   BODY: one value byte/cycle; byte = {rem>7'h7f, rem[6:0]}, rem >>= 7; last when rem[63:7]==0.
//   BODY -> IDLE after last byte.
//  Value 0 encodes as single byte 0x00. Length is 1..10 bytes; INT32 negative is always 10 bytes.
//  A byte is written only if the FIFO is not full; otherwise the FSM holds (no loss, no duplicate).
//  in_ready=1 only in IDLE and not in reset. Exactly one message is in flight in the encoder.
//  m_last is set only on the final value byte; msg_len counts key+value bytes.
//  FIFO: first-word-fall-through; m_data/m_last are valid whenever m_valid=1.
//   Pop when m_valid & m_ready. Simultaneous push+pop when full is allowed (level unchanged).
//   Pointers wrap modulo FIFO_DEPTH; fifo_level uses one extra bit to distinguish full from empty.
//  Latency: accept at cycle N -> first byte visible on m_valid at N+1 if FIFO empty.
//  Throughput: 1 byte/cycle sustained with m_ready=1; next word is accepted the cycle after BODY->IDLE.
//  AXI register-map glue stays outside this block; it drives in_* and drains m_*.
// STRUCTURE
//  pb_pkg: typedef enum pb_kind_e {RAW32, RAW64, INT32, SINT64}; FSM state enum {IDLE, KEY, BODY};
//   localparam PB_MAX_VARINT_BYTES=10; function zigzag64().
//  Sub-module pb_byte_fifo (#DEPTH, WIDTH=9): sync FWFT FIFO with level output.
//   The encoder FSM and normaliser live in this module.
// TESTING
//  T1 RAW32 10, 127, 128 back-to-back, m_ready=1 -> 0a | 7f | 80 01; m_last on 0a, 7f, 01;
//     msg_len 1, 1, 2.
//  T2 RAW64 64'h0000_0806_aeb4_8f8a -> 8a 9f d2 f5 ea 80 02 (7 bytes).
//     RAW32 32'haeb48f8a -> 8a 9f d2 f5 0a.
//  T3 INT32 -1 -> ff ff ff ff ff ff ff ff ff 01 (10 bytes).
//     SINT64 -1, 1, -2, 0 -> 01 | 02 | 03 | 00.
//  T4 tag=1, field=1, RAW32 150 -> 08 96 01, msg_len=3.
//     field=16, RAW32 1 -> 80 01 01. TAG_EN=0 build: same stimulus -> 96 01.
//  T5 m_ready=0, 4 words of RAW64 64'hffff_ffff_ffff_ffff -> FIFO fills to FIFO_DEPTH, FSM stalls,
//     in_ready=0. Then random m_ready -> exact byte stream, no loss, no duplicates.
//     Check fifo_level at full and across pointer wrap.
//  T6 assert rst_n low during BODY of a 10-byte message -> m_valid=0, fifo_level=0 asynchronously.
//     After release, RAW32 5 -> 05 only.

Source files
------------

// File: rtl/protobuf_varint_encoder_pkg.sv
// Shared types and helpers for the protobuf varint encoder: input kinds,
// FSM state encoding, message length sizing and value normalisation.
package protobuf_varint_encoder_pkg;

    typedef enum logic [1:0] {
        RAW32  = 2'd0,
        RAW64  = 2'd1,
        INT32  = 2'd2,
        SINT64 = 2'd3
    } pb_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_BODY = 2'd2
    } pb_state_e;

    localparam int PB_MAX_VARINT_BYTES = 10;
    // Room for a full value plus a two-byte key (1..12 bytes per message).
    localparam int PB_LEN_W = $clog2(PB_MAX_VARINT_BYTES + 3);

    function automatic logic [63:0] zigzag64(input logic [63:0] d);
        return (d << 1) ^ {64{d[63]}};
    endfunction

    // Map the typed input word onto the unsigned 64-bit value that gets LEB128-encoded.
    function automatic logic [63:0] pb_normalise(input pb_kind_e kind, input logic [63:0] d);
        logic [63:0] v;
        case (kind)
            RAW32:   v = {32'd0, d[31:0]};
            RAW64:   v = d;
            INT32:   v = {{32{d[31]}}, d[31:0]};
            default: v = zigzag64(d);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/protobuf_varint_encoder_if.sv
// Word-in / byte-out handshake bundle of the varint encoder.
// master = producer of words and consumer of bytes, slave = the encoder.
interface protobuf_varint_encoder_if #(
    parameter int FIELD_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_data;
    logic [1:0]         in_kind;
    logic               in_tag;
    logic [FIELD_W-1:0] in_field;
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         m_data;
    logic               m_last;

    modport master (
        output in_valid, in_data, in_kind, in_tag, in_field, m_ready,
        input  in_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  in_valid, in_data, in_kind, in_tag, in_field, m_ready,
        output in_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/protobuf_varint_encoder_fifo.sv
// First-word-fall-through byte FIFO with occupancy output. Power-of-two depth,
// pointers wrap naturally; the level counter carries one extra bit so that
// full and empty are distinct. Read data is forced to zero while empty.
module protobuf_varint_encoder_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer/level update; a push into a full FIFO is taken only alongside a pop.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/protobuf_varint_encoder.sv
// Protobuf varint encoder: accepts one typed word per handshake, optionally
// emits the field key first, then the LEB128 bytes of the normalised value
// into an output FIFO. One message is in flight at a time.
module protobuf_varint_encoder
    import protobuf_varint_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int FIELD_W    = 5,
    parameter bit TAG_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    protobuf_varint_encoder_if.slave      bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          msg_done,
    output logic [PB_LEN_W-1:0]           msg_len
);
    pb_state_e           state_q, state_d;
    logic [63:0]         key_q, key_d, val_q, val_d;
    logic [PB_LEN_W-1:0] len_q, len_d, msg_len_q, msg_len_d;
    logic                msg_done_q, msg_done_d;
    logic                in_ready_q, in_ready_d;
    logic                accept, push, key_last, val_last;
    logic                fifo_full, fifo_empty, pop;
    logic [8:0]          push_data, pop_data;

    assign accept   = bus.in_valid & in_ready_q;
    assign key_last = (key_q[63:7] == '0);
    assign val_last = (val_q[63:7] == '0);

    // Encoder FSM: latch word and key on accept, then one byte per cycle while the FIFO has room.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        val_d      = val_q;
        len_d      = len_q;
        msg_len_d  = msg_len_q;
        msg_done_d = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    val_d   = pb_normalise(pb_kind_e'(bus.in_kind), bus.in_data);
                    key_d   = 64'({bus.in_field, 3'b000});
                    len_d   = '0;
                    state_d = (TAG_EN && bus.in_tag) ? ST_KEY : ST_BODY;
                end
            end
            ST_KEY: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = {1'b0, ~key_last, key_q[6:0]};
                    key_d     = key_q >> 7;
                    len_d     = len_q + PB_LEN_W'(1);
                    if (key_last) begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = {val_last, ~val_last, val_q[6:0]};
                    val_d     = val_q >> 7;
                    len_d     = len_q + PB_LEN_W'(1);
                    if (val_last) begin
                        state_d    = ST_IDLE;
                        msg_done_d = 1'b1;
                        msg_len_d  = len_q + PB_LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // FSM and registered outputs; in_ready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            val_q      <= '0;
            len_q      <= '0;
            msg_len_q  <= '0;
            msg_done_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            val_q      <= val_d;
            len_q      <= len_d;
            msg_len_q  <= msg_len_d;
            msg_done_q <= msg_done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign pop = ~fifo_empty & bus.m_ready;

    protobuf_varint_encoder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.m_valid  = ~fifo_empty;
    assign bus.m_data   = pop_data[7:0];
    assign bus.m_last   = pop_data[8];
    assign msg_done     = msg_done_q;
    assign msg_len      = msg_len_q;
endmodule

// File: tb/tb_protobuf_varint_encoder.sv
// Bench for protobuf_varint_encoder: table of known encodings, hand-written
// backpressure/reset sequences and randomized words against a reference model.
// A second instance built without key emission runs on the same input stream.
module tb_protobuf_varint_encoder;
    import protobuf_varint_encoder_pkg::*;

    localparam int DEPTH   = 32;
    localparam int FIELD_W = 5;

    logic clk;
    logic rst_n;
    logic [$clog2(DEPTH):0] level1, level2;
    logic msg_done1, msg_done2;
    logic [PB_LEN_W-1:0] msg_len1, msg_len2;

    protobuf_varint_encoder_if #(.FIELD_W(FIELD_W)) bus1 ();
    protobuf_varint_encoder_if #(.FIELD_W(FIELD_W)) bus2 ();

    protobuf_varint_encoder #(.FIFO_DEPTH(DEPTH), .FIELD_W(FIELD_W), .TAG_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .fifo_level(level1), .msg_done(msg_done1), .msg_len(msg_len1));

    protobuf_varint_encoder #(.FIFO_DEPTH(DEPTH), .FIELD_W(FIELD_W), .TAG_EN(1'b0)) dut_notag (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .fifo_level(level2), .msg_done(msg_done2), .msg_len(msg_len2));

    // The key-less instance never takes longer than the main one, so it is idle whenever the main one is.
    assign bus2.in_valid = bus1.in_valid & bus1.in_ready;
    assign bus2.in_data  = bus1.in_data;
    assign bus2.in_kind  = bus1.in_kind;
    assign bus2.in_tag   = bus1.in_tag;
    assign bus2.in_field = bus1.in_field;
    assign bus2.m_ready  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 0;   // 0: hold m_ready low, 1: high, 2: random

    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];
    int         len_q[$];
    logic [8:0] got1[$];
    logic [8:0] got2[$];
    int         last_len = 0;

    typedef logic [7:0] byteq_t[$];

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_value(input int kind, input logic [63:0] d);
        longint s;
        case (kind)
            0: return {32'd0, d[31:0]};
            1: return d;
            2: begin s = longint'(int'(d[31:0])); return s; end
            default: begin s = d; return (s <<< 1) ^ (s >>> 63); end
        endcase
    endfunction

    function automatic byteq_t leb128(input logic [63:0] v_in);
        byteq_t q;
        logic [63:0] v;
        logic [7:0]  b;
        v = v_in;
        do begin
            b = 8'(v % 64'd128);
            v = v / 64'd128;
            if (v != 0) b = b + 8'd128;
            q.push_back(b);
        end while (v != 0);
        return q;
    endfunction

    task automatic model_encode(input int kind, input logic [63:0] d, input bit tag, input logic [FIELD_W-1:0] field);
        byteq_t kq, vq;
        vq = leb128(model_value(kind, d));
        kq = {};
        if (tag) kq = leb128(64'(field) * 64'd8);
        foreach (kq[i]) exp_q.push_back({1'b0, kq[i]});
        foreach (vq[i]) begin
            exp_q.push_back({(i == vq.size() - 1), vq[i]});
            exp2_q.push_back({(i == vq.size() - 1), vq[i]});
        end
        len_q.push_back(kq.size() + vq.size());
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_tests++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus1.m_valid && bus1.m_ready) begin
                got1.push_back({bus1.m_last, bus1.m_data});
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream: got %03h, expected no byte", {bus1.m_last, bus1.m_data});
                end else if (exp_q[0] !== {bus1.m_last, bus1.m_data}) begin
                    n_fail++;
                    $display("FAIL stream: got %03h, expected %03h", {bus1.m_last, bus1.m_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (bus2.m_valid) begin
                got2.push_back({bus2.m_last, bus2.m_data});
                n_tests++;
                if (exp2_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL notag_stream: got %03h, expected no byte", {bus2.m_last, bus2.m_data});
                end else begin
                    if (exp2_q[0] !== {bus2.m_last, bus2.m_data}) begin
                        n_fail++;
                        $display("FAIL notag_stream: got %03h, expected %03h", {bus2.m_last, bus2.m_data}, exp2_q[0]);
                    end
                    void'(exp2_q.pop_front());
                end
            end
            if (msg_done1) begin
                last_len = int'(msg_len1);
                n_tests++;
                if (len_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL msg_len: got %0d, expected no message", msg_len1);
                end else begin
                    if (int'(msg_len1) != len_q[0]) begin
                        n_fail++;
                        $display("FAIL msg_len: got %0d, expected %0d", msg_len1, len_q[0]);
                    end
                    void'(len_q.pop_front());
                end
            end
        end
    end

    // m_ready driver: changes only just after a rising edge.
    initial begin
        bus1.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus1.m_ready = 1'b0;
                1:       bus1.m_ready = 1'b1;
                default: bus1.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int kind, input logic [63:0] d, input bit tag, input logic [FIELD_W-1:0] field);
        int waited;
        $display("[TB] word kind=%0d data=%016h tag=%0d field=%0d", kind, d, tag, field);
        model_encode(kind, d, tag, field);
        bus1.in_valid = 1'b1;
        bus1.in_kind  = 2'(kind);
        bus1.in_data  = d;
        bus1.in_tag   = tag;
        bus1.in_field = field;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus1.in_ready && waited < 400);
        if (!bus1.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 400 cycles");
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size() + exp2_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                 kind;
        logic [63:0]        data;
        bit                 tag;
        logic [FIELD_W-1:0] field;
        int                 n;
        logic [95:0]        bytes;   // first byte in the most significant used position
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [8:0] e;
        logic [8:0] a;

        vecs[0]  = '{0, 64'd10,                  1'b0, 5'd0,  1,  96'h0a};
        vecs[1]  = '{0, 64'd127,                 1'b0, 5'd0,  1,  96'h7f};
        vecs[2]  = '{0, 64'd128,                 1'b0, 5'd0,  2,  96'h8001};
        vecs[3]  = '{1, 64'h0000_0806_aeb4_8f8a, 1'b0, 5'd0,  7,  96'h8a9fd2f5ea8002};
        vecs[4]  = '{0, 64'hdead_beef_aeb4_8f8a, 1'b0, 5'd0,  5,  96'h8a9fd2f50a};
        vecs[5]  = '{2, 64'h1234_5678_ffff_ffff, 1'b0, 5'd0,  10, 96'hffffffffffffffffff01};
        vecs[6]  = '{3, 64'hffff_ffff_ffff_ffff, 1'b0, 5'd0,  1,  96'h01};
        vecs[7]  = '{3, 64'd1,                   1'b0, 5'd0,  1,  96'h02};
        vecs[8]  = '{3, 64'hffff_ffff_ffff_fffe, 1'b0, 5'd0,  1,  96'h03};
        vecs[9]  = '{3, 64'd0,                   1'b0, 5'd0,  1,  96'h00};
        vecs[10] = '{0, 64'd150,                 1'b1, 5'd1,  3,  96'h089601};
        vecs[11] = '{0, 64'd1,                   1'b1, 5'd16, 3,  96'h800101};
        vecs[12] = '{1, 64'hffff_ffff_ffff_ffff, 1'b0, 5'd0,  10, 96'hffffffffffffffffff01};
        vecs[13] = '{1, 64'h8000_0000_0000_0000, 1'b1, 5'd0,  11, 96'h0080808080808080808001};

        bus1.in_valid = 1'b0;
        bus1.in_kind  = 2'd0;
        bus1.in_data  = '0;
        bus1.in_tag   = 1'b0;
        bus1.in_field = '0;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", bus1.in_ready, 0);
        check("reset_m_valid", bus1.m_valid, 0);
        check("reset_m_data", bus1.m_data, 0);
        check("reset_m_last", bus1.m_last, 0);
        check("reset_fifo_level", level1, 0);
        check("reset_msg_done", msg_done1, 0);
        check("reset_msg_len", msg_len1, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", bus1.in_ready, 1);

        // Table of known encodings, one message at a time
        ready_mode = 1;
        foreach (vecs[v]) begin
            got1.delete();
            send(vecs[v].kind, vecs[v].data, vecs[v].tag, vecs[v].field);
            drain();
            check($sformatf("vec%0d_count", v), got1.size(), vecs[v].n);
            check($sformatf("vec%0d_msg_len", v), last_len, vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++) begin
                e = {(i == vecs[v].n - 1), vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]};
                a = (i < got1.size()) ? got1[i] : 9'h1ff;
                check($sformatf("vec%0d_byte%0d", v, i), a, e);
            end
        end

        // Key emission disabled: same keyed word yields the value bytes only
        got2.delete();
        send(0, 64'd150, 1'b1, 5'd1);
        drain();
        check("notag_count", got2.size(), 2);
        check("notag_byte0", got2[0], 9'h096);
        check("notag_byte1", got2[1], 9'h101);

        // Back-to-back single-byte words
        got1.delete();
        send(0, 64'd10, 1'b0, 5'd0);
        send(0, 64'd127, 1'b0, 5'd0);
        send(0, 64'd128, 1'b0, 5'd0);
        drain();
        check("b2b_count", got1.size(), 4);
        check("b2b_byte0", got1[0], 9'h10a);
        check("b2b_byte1", got1[1], 9'h17f);
        check("b2b_byte2", got1[2], 9'h080);
        check("b2b_byte3", got1[3], 9'h101);

        // Backpressure: fill the FIFO completely and stall the encoder
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) send(1, 64'hffff_ffff_ffff_ffff, 1'b0, 5'd0);
        repeat (6) @(posedge clk);
        #1;
        check("full_level", level1, DEPTH);
        check("full_in_ready", bus1.in_ready, 0);
        check("full_m_valid", bus1.m_valid, 1);
        ready_mode = 2;
        drain();
        check("drained_level", level1, 0);

        // Level after pointers have wrapped
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(1, 64'hffff_ffff_ffff_ffff, 1'b0, 5'd0);
        repeat (14) @(posedge clk);
        #1;
        check("wrap_level", level1, 10);
        ready_mode = 1;
        drain();

        // Randomized words with random backpressure
        ready_mode = 2;
        for (int r = 0; r < 150; r++) begin
            logic [63:0] d;
            d = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
            send($urandom_range(0, 3), d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        drain();

        // Reset in the middle of a 10-byte message
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(2, 64'h0000_0000_ffff_ffff, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_m_valid", bus1.m_valid, 0);
        check("midreset_level", level1, 0);
        check("midreset_in_ready", bus1.in_ready, 0);
        exp_q.delete();
        exp2_q.delete();
        len_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_in_ready", bus1.in_ready, 1);
        check("postreset_m_valid", bus1.m_valid, 0);
        got1.delete();
        ready_mode = 1;
        send(0, 64'd5, 1'b0, 5'd0);
        drain();
        check("postreset_count", got1.size(), 1);
        check("postreset_byte", got1[0], 9'h105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
